// File: rtl/neural_pkg.sv
// Shared encodings for the neuron activation pipeline: activation modes
// and the pass-control FSM states.
`timescale 1ns/1ps
package neural_pkg;

  typedef enum logic [1:0] {
    ACT_RELU   = 2'b00,
    ACT_LEAKY  = 2'b01,
    ACT_LINEAR = 2'b10,
    ACT_CLIP   = 2'b11
  } act_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/neuron_act_pipe_if.sv
// Accumulator input stream and activated result stream of the neuron
// pipeline. The pipeline itself is the slave; the producer/consumer the master.
`timescale 1ns/1ps
interface neuron_act_pipe_if #(
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8
);
  logic signed [ACC_WIDTH-1:0] in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/neuron_act_pipe_act_sat.sv
// Combinational activation followed by saturation into the signed output
// range. The clip-mode ceiling is part of the activation, so it never
// raises the saturation indication by itself.
`timescale 1ns/1ps
module act_sat_unit
  import neural_pkg::*;
#(
  parameter int ACC_WIDTH  = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int CLIP_MAX   = 63
) (
  input  logic signed [ACC_WIDTH:0]   sum_i,
  input  act_mode_e                   mode_i,
  output logic signed [OUT_WIDTH-1:0] act_o,
  output logic                        sat_o
);
  localparam int SW = ACC_WIDTH + 1;
  localparam logic signed [SW-1:0] OMAX =
    $signed({{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [SW-1:0] OMIN = ~OMAX;
  localparam logic signed [SW-1:0] CMAX = SW'(CLIP_MAX);

  // Returns {clamped, value} for a full-width activation result.
  function automatic logic [OUT_WIDTH:0] sat_out(input logic signed [SW-1:0] v);
    if (v > OMAX)      return {1'b1, OMAX[OUT_WIDTH-1:0]};
    else if (v < OMIN) return {1'b1, OMIN[OUT_WIDTH-1:0]};
    else               return {1'b0, v[OUT_WIDTH-1:0]};
  endfunction

  logic signed [SW-1:0] act_s;

  // Activation at full sum width, before narrowing.
  always_comb begin
    act_s = sum_i;
    case (mode_i)
      ACT_RELU:   act_s = (sum_i < 0) ? '0 : sum_i;
      ACT_LEAKY:  act_s = (sum_i < 0) ? (sum_i >>> LEAK_SHIFT) : sum_i;
      ACT_LINEAR: act_s = sum_i;
      ACT_CLIP: begin
        if (sum_i < 0)         act_s = '0;
        else if (sum_i > CMAX) act_s = CMAX;
        else                   act_s = sum_i;
      end
      default:    act_s = sum_i;
    endcase
  end

  assign {sat_o, act_o} = sat_out(act_s);

endmodule

// File: rtl/neuron_act_pipe.sv
// Per-layer activation pipeline: adds a stored per-neuron bias to each
// accumulator value, applies the pass-selected activation and saturates.
// Two register stages (sum, result); a stalled output freezes everything.
`timescale 1ns/1ps
module neuron_act_pipe
  import neural_pkg::*;
#(
  parameter int M          = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int BIAS_WIDTH = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int CLIP_MAX   = 63
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [1:0]                   act_mode,
  input  logic                         bias_wen,
  input  logic [$clog2(M)-1:0]         bias_addr,
  input  logic signed [BIAS_WIDTH-1:0] bias_in,
  neuron_act_pipe_if.slave             s_if,
  output logic                         busy,
  output logic                         done,
  output logic                         sat_flag
);
  localparam int IDX_W = $clog2(M);
  localparam int CNT_W = $clog2(M + 1);
  localparam int SW    = ACC_WIDTH + 1;

  state_e                       state_q, state_d;
  act_mode_e                    mode_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [IDX_W-1:0]             idx;
  logic signed [BIAS_WIDTH-1:0] bias_mem [M];

  logic signed [SW-1:0]         sum_p1;
  logic                         vld_p1, last_p1;
  logic signed [OUT_WIDTH-1:0]  data_p2;
  logic                         vld_p2, last_p2;

  logic                         sat_flag_q, done_q;
  logic                         stall, accept, start_acc, last_xfer;
  logic signed [SW-1:0]         in_ext, bias_ext;
  logic signed [OUT_WIDTH-1:0]  act_val;
  logic                         act_sat;

  assign idx       = cnt_q[IDX_W-1:0];
  assign stall     = vld_p2 & ~s_if.out_ready;
  assign start_acc = start & (state_q == ST_IDLE);
  assign accept    = s_if.in_valid & s_if.in_ready;
  assign last_xfer = vld_p2 & last_p2 & s_if.out_ready;
  assign in_ext    = {s_if.in_data[ACC_WIDTH-1], s_if.in_data};
  assign bias_ext  = {{(SW-BIAS_WIDTH){bias_mem[idx][BIAS_WIDTH-1]}}, bias_mem[idx]};

  assign s_if.in_ready  = (state_q == ST_RUN) && (cnt_q < CNT_W'(M)) && !stall;
  assign s_if.out_data  = data_p2;
  assign s_if.out_valid = vld_p2;
  assign s_if.out_last  = last_p2;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign sat_flag       = sat_flag_q;

  // Pass sequencing: accept M inputs, then drain until the last result leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (accept && (cnt_q == CNT_W'(M-1))) state_d = ST_DRAIN;
      ST_DRAIN: if (last_xfer) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register, input neuron index and activation mode latched per pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= ACT_RELU;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        cnt_q  <= '0;
        mode_q <= act_mode_e'(act_mode);
      end else if (accept) begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  // Bias table, writable only between passes and deliberately kept over reset.
  always_ff @(posedge clk) begin
    if (bias_wen && (state_q == ST_IDLE)) bias_mem[bias_addr] <= bias_in;
  end

  // ---- stage p1: bias addition, one bit wider so it can never wrap ----
  // Sum register loads only on an accepted input.
  always_ff @(posedge clk) begin
    if (accept) sum_p1 <= in_ext + bias_ext;
  end

  // Stage p1 valid and last-neuron marker, frozen while the output stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1  <= accept;
      last_p1 <= accept && (idx == IDX_W'(M-1));
    end
  end

  act_sat_unit #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .LEAK_SHIFT(LEAK_SHIFT),
    .CLIP_MAX  (CLIP_MAX)
  ) u_act_sat (
    .sum_i (sum_p1),
    .mode_i(mode_q),
    .act_o (act_val),
    .sat_o (act_sat)
  );

  // ---- stage p2: activated, saturated result presented on the output ----
  // Output register holds its contents while the consumer is not ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      data_p2 <= '0;
    end else if (!stall) begin
      vld_p2  <= vld_p1;
      last_p2 <= vld_p1 & last_p1;
      if (vld_p1) data_p2 <= act_val;
    end
  end

  // End-of-pass pulse and sticky saturation indication for the current pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q     <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      done_q <= last_xfer;
      if (start_acc)                       sat_flag_q <= 1'b0;
      else if (vld_p1 && !stall && act_sat) sat_flag_q <= 1'b1;
    end
  end

endmodule
